sram_pair_req_sched: RTL and testbench

Initiator side of the two-instance SRAM hash-group pair. It accepts two independent read/write request channels (A, B) and issues at most one command per SRAM instance per cycle onto the pair's port-A/port-B read and write command buses. It resolves same-instance conflicts with round-robin arbitration and returns read data tagged to the originating channel.

---
 rtl/sram_pair_req_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_sram_pair_req_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pair_req_sched.sv
// Request scheduler for a two-instance SRAM pair: two channels, round-robin on instance conflicts.
// Optional SRAM_PAIR_SCHED_STAT_EN adds conflict_cnt and a same-bus sel check.
module sram_pair_req_sched #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld_a,
  output logic              req_rdy_a,
  input  logic              req_wr_a,
  input  logic              req_sel_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [31:0]       req_wdata_a,
  input  logic [TAG_W-1:0]  req_tag_a,
  input  logic              req_vld_b,
  output logic              req_rdy_b,
  input  logic              req_wr_b,
  input  logic              req_sel_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [31:0]       req_wdata_b,
  input  logic [TAG_W-1:0]  req_tag_b,
  output logic              rd_vld_a,
  output logic              rd_sel_a,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic              rd_vld_b,
  output logic              rd_sel_b,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              wr_vld_a,
  output logic              wr_sel_a,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [31:0]       wr_data_a,
  output logic              wr_vld_b,
  output logic              wr_sel_b,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [31:0]       wr_data_b,
  input  logic [31:0]       rd_data_a,
  input  logic [31:0]       rd_data_b,
  output logic              resp_vld_a,
  output logic [TAG_W-1:0]  resp_tag_a,
  output logic [31:0]       resp_data_a,
  output logic              resp_vld_b,
  output logic [TAG_W-1:0]  resp_tag_b,
  output logic [31:0]       resp_data_b
`ifdef SRAM_PAIR_SCHED_STAT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  logic              hold_vld_a, hold_wr_a, hold_sel_a;
  logic [ADDR_W-1:0] hold_addr_a;
  logic [31:0]       hold_wdata_a;
  logic [TAG_W-1:0]  hold_tag_a;
  logic              hold_vld_b, hold_wr_b, hold_sel_b;
  logic [ADDR_W-1:0] hold_addr_b;
  logic [31:0]       hold_wdata_b;
  logic [TAG_W-1:0]  hold_tag_b;

  logic              rr_ptr;  // 0: channel A wins the next conflict
  logic              conflict, grant_a, grant_b;
  logic              rd_go_a, rd_go_b, wr_go_a, wr_go_b;
  logic              rd_sel_a_d, rd_sel_b_d, wr_sel_a_d, wr_sel_b_d;
  logic [TAG_W-1:0]  rd_tag_a_q, rd_tag_b_q;

  logic [RD_LAT-1:0] pipe_vld_a, pipe_vld_b;
  logic [TAG_W-1:0]  pipe_tag_a [RD_LAT];
  logic [TAG_W-1:0]  pipe_tag_b [RD_LAT];

  // Occupancy is by instance only, so a read and a write to one instance also conflict.
  always_comb begin
    conflict = hold_vld_a && hold_vld_b && (hold_sel_a == hold_sel_b);
    grant_a  = hold_vld_a && (!conflict || !rr_ptr);
    grant_b  = hold_vld_b && (!conflict || rr_ptr);
    rd_go_a  = grant_a && !hold_wr_a;
    wr_go_a  = grant_a && hold_wr_a;
    rd_go_b  = grant_b && !hold_wr_b;
    wr_go_b  = grant_b && hold_wr_b;
    // An idle slot mirrors the active slot's sel so the pair never sees equal sels.
    rd_sel_a_d = rd_go_a ? hold_sel_a : (rd_go_b ? !hold_sel_b : 1'b1);
    rd_sel_b_d = rd_go_b ? hold_sel_b : (rd_go_a ? !hold_sel_a : 1'b0);
    wr_sel_a_d = wr_go_a ? hold_sel_a : (wr_go_b ? !hold_sel_b : 1'b1);
    wr_sel_b_d = wr_go_b ? hold_sel_b : (wr_go_a ? !hold_sel_a : 1'b0);
  end

  assign req_rdy_a = !hold_vld_a || grant_a;
  assign req_rdy_b = !hold_vld_b || grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_a   <= 1'b0;
      hold_wr_a    <= 1'b0;
      hold_sel_a   <= 1'b0;
      hold_addr_a  <= '0;
      hold_wdata_a <= '0;
      hold_tag_a   <= '0;
      hold_vld_b   <= 1'b0;
      hold_wr_b    <= 1'b0;
      hold_sel_b   <= 1'b0;
      hold_addr_b  <= '0;
      hold_wdata_b <= '0;
      hold_tag_b   <= '0;
      rr_ptr       <= 1'b0;
    end else begin
      if (req_vld_a && req_rdy_a) begin
        hold_vld_a   <= 1'b1;
        hold_wr_a    <= req_wr_a;
        hold_sel_a   <= req_sel_a;
        hold_addr_a  <= req_addr_a;
        hold_wdata_a <= req_wdata_a;
        hold_tag_a   <= req_tag_a;
      end else if (grant_a) begin
        hold_vld_a <= 1'b0;
      end
      if (req_vld_b && req_rdy_b) begin
        hold_vld_b   <= 1'b1;
        hold_wr_b    <= req_wr_b;
        hold_sel_b   <= req_sel_b;
        hold_addr_b  <= req_addr_b;
        hold_wdata_b <= req_wdata_b;
        hold_tag_b   <= req_tag_b;
      end else if (grant_b) begin
        hold_vld_b <= 1'b0;
      end
      if (conflict) rr_ptr <= !rr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_a   <= 1'b0;
      rd_sel_a   <= 1'b1;
      rd_addr_a  <= '0;
      rd_tag_a_q <= '0;
      rd_vld_b   <= 1'b0;
      rd_sel_b   <= 1'b0;
      rd_addr_b  <= '0;
      rd_tag_b_q <= '0;
      wr_vld_a   <= 1'b0;
      wr_sel_a   <= 1'b1;
      wr_addr_a  <= '0;
      wr_data_a  <= '0;
      wr_vld_b   <= 1'b0;
      wr_sel_b   <= 1'b0;
      wr_addr_b  <= '0;
      wr_data_b  <= '0;
    end else begin
      rd_vld_a <= rd_go_a;
      rd_sel_a <= rd_sel_a_d;
      rd_vld_b <= rd_go_b;
      rd_sel_b <= rd_sel_b_d;
      wr_vld_a <= wr_go_a;
      wr_sel_a <= wr_sel_a_d;
      wr_vld_b <= wr_go_b;
      wr_sel_b <= wr_sel_b_d;
      if (rd_go_a) begin
        rd_addr_a  <= hold_addr_a;
        rd_tag_a_q <= hold_tag_a;
      end
      if (rd_go_b) begin
        rd_addr_b  <= hold_addr_b;
        rd_tag_b_q <= hold_tag_b;
      end
      if (wr_go_a) begin
        wr_addr_a <= hold_addr_a;
        wr_data_a <= hold_wdata_a;
      end
      if (wr_go_b) begin
        wr_addr_b <= hold_addr_b;
        wr_data_b <= hold_wdata_b;
      end
    end
  end

  // Response pipeline tracks the SRAM read latency so vld/tag line up with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_a <= '0;
      pipe_vld_b <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_tag_a[i] <= '0;
        pipe_tag_b[i] <= '0;
      end
    end else begin
      pipe_vld_a[0] <= rd_vld_a;
      pipe_vld_b[0] <= rd_vld_b;
      pipe_tag_a[0] <= rd_tag_a_q;
      pipe_tag_b[0] <= rd_tag_b_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_a[i] <= pipe_vld_a[i-1];
        pipe_vld_b[i] <= pipe_vld_b[i-1];
        pipe_tag_a[i] <= pipe_tag_a[i-1];
        pipe_tag_b[i] <= pipe_tag_b[i-1];
      end
    end
  end

  assign resp_vld_a  = pipe_vld_a[RD_LAT-1];
  assign resp_tag_a  = pipe_tag_a[RD_LAT-1];
  assign resp_data_a = rd_data_a;
  assign resp_vld_b  = pipe_vld_b[RD_LAT-1];
  assign resp_tag_b  = pipe_tag_b[RD_LAT-1];
  assign resp_data_b = rd_data_b;

`ifdef SRAM_PAIR_SCHED_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rd_vld_a && rd_vld_b && (rd_sel_a == rd_sel_b)))
        else $error("read bus carries two valid commands with equal sel");
      assert (!(wr_vld_a && wr_vld_b && (wr_sel_a == wr_sel_b)))
        else $error("write bus carries two valid commands with equal sel");
    end
  end
`endif

endmodule

// File: tb/tb_sram_pair_req_sched.sv
// Bench for sram_pair_req_sched: directed scenarios, then random traffic checked against
// a per-channel in-order reference of the SRAM contents.
module tb_sram_pair_req_sched;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned RD_LAT = 1;

  logic              clk, rst;
  logic              req_vld_a, req_rdy_a, req_wr_a, req_sel_a;
  logic [ADDR_W-1:0] req_addr_a;
  logic [31:0]       req_wdata_a;
  logic [TAG_W-1:0]  req_tag_a;
  logic              req_vld_b, req_rdy_b, req_wr_b, req_sel_b;
  logic [ADDR_W-1:0] req_addr_b;
  logic [31:0]       req_wdata_b;
  logic [TAG_W-1:0]  req_tag_b;
  logic              rd_vld_a, rd_sel_a, rd_vld_b, rd_sel_b;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b;
  logic              wr_vld_a, wr_sel_a, wr_vld_b, wr_sel_b;
  logic [ADDR_W-1:0] wr_addr_a, wr_addr_b;
  logic [31:0]       wr_data_a, wr_data_b, rd_data_a, rd_data_b;
  logic              resp_vld_a, resp_vld_b;
  logic [TAG_W-1:0]  resp_tag_a, resp_tag_b;
  logic [31:0]       resp_data_a, resp_data_b;
`ifdef SRAM_PAIR_SCHED_STAT_EN
  logic [15:0]       conflict_cnt;
`endif

  sram_pair_req_sched #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_vld_a(req_vld_a), .req_rdy_a(req_rdy_a), .req_wr_a(req_wr_a), .req_sel_a(req_sel_a),
    .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a), .req_tag_a(req_tag_a),
    .req_vld_b(req_vld_b), .req_rdy_b(req_rdy_b), .req_wr_b(req_wr_b), .req_sel_b(req_sel_b),
    .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b), .req_tag_b(req_tag_b),
    .rd_vld_a(rd_vld_a), .rd_sel_a(rd_sel_a), .rd_addr_a(rd_addr_a),
    .rd_vld_b(rd_vld_b), .rd_sel_b(rd_sel_b), .rd_addr_b(rd_addr_b),
    .wr_vld_a(wr_vld_a), .wr_sel_a(wr_sel_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_vld_b(wr_vld_b), .wr_sel_b(wr_sel_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .resp_vld_a(resp_vld_a), .resp_tag_a(resp_tag_a), .resp_data_a(resp_data_a),
    .resp_vld_b(resp_vld_b), .resp_tag_b(resp_tag_b), .resp_data_b(resp_data_b)
`ifdef SRAM_PAIR_SCHED_STAT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read back as a fixed function of their location.
  function automatic logic [31:0] init_val(input logic sel, input logic [ADDR_W-1:0] addr);
    return {(sel ? 16'hA5C3 : 16'h3C5A), 6'd0, addr};
  endfunction

  // SRAM pair model with one-cycle registered reads.
  logic [31:0] mem   [2][1024];
  bit          wflag [2][1024];
  always @(posedge clk) begin
    if (rd_vld_a) rd_data_a <= wflag[rd_sel_a][rd_addr_a] ? mem[rd_sel_a][rd_addr_a]
                                                          : init_val(rd_sel_a, rd_addr_a);
    if (rd_vld_b) rd_data_b <= wflag[rd_sel_b][rd_addr_b] ? mem[rd_sel_b][rd_addr_b]
                                                          : init_val(rd_sel_b, rd_addr_b);
    if (wr_vld_a) begin
      mem[wr_sel_a][wr_addr_a]   <= wr_data_a;
      wflag[wr_sel_a][wr_addr_a] <= 1'b1;
    end
    if (wr_vld_b) begin
      mem[wr_sel_b][wr_addr_b]   <= wr_data_b;
      wflag[wr_sel_b][wr_addr_b] <= 1'b1;
    end
  end

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] refm [2][1024];
  bit          refw [2][1024];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic sel, input logic [ADDR_W-1:0] addr);
    return refw[sel][addr] ? refm[sel][addr] : init_val(sel, addr);
  endfunction

  // Each channel is served in order, so the reference updates at acceptance time.
  task automatic accept(input bit ch, input logic wr, input logic sel,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        input logic [TAG_W-1:0] tag);
    if (wr) begin
      refm[sel][addr] = wd;
      refw[sel][addr] = 1'b1;
    end else if (ch == 1'b0) begin
      q_a.push_back('{tag: tag, data: ref_rd(sel, addr)});
    end else begin
      q_b.push_back('{tag: tag, data: ref_rd(sel, addr)});
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   occ0, occ1;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      return;
    end
    if (resp_vld_a) begin
      check("resp_a_expected", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("resp_tag_a", 64'(resp_tag_a), 64'(e.tag));
        check("resp_data_a", 64'(resp_data_a), 64'(e.data));
      end
    end
    if (resp_vld_b) begin
      check("resp_b_expected", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("resp_tag_b", 64'(resp_tag_b), 64'(e.tag));
        check("resp_data_b", 64'(resp_data_b), 64'(e.data));
      end
    end
    if (req_vld_a && req_rdy_a)
      accept(1'b0, req_wr_a, req_sel_a, req_addr_a, req_wdata_a, req_tag_a);
    if (req_vld_b && req_rdy_b)
      accept(1'b1, req_wr_b, req_sel_b, req_addr_b, req_wdata_b, req_tag_b);
    // The two slots of a bus always carry opposite sels, active or idle.
    check("rd_sel_opposite", 64'(rd_sel_a ^ rd_sel_b), 64'd1);
    check("wr_sel_opposite", 64'(wr_sel_a ^ wr_sel_b), 64'd1);
    if (!rd_vld_a && !rd_vld_b) check("rd_idle_sel_a", 64'(rd_sel_a), 64'd1);
    if (!wr_vld_a && !wr_vld_b) check("wr_idle_sel_a", 64'(wr_sel_a), 64'd1);
    occ0 = 0;
    occ1 = 0;
    if (rd_vld_a) begin if (rd_sel_a) occ1++; else occ0++; end
    if (rd_vld_b) begin if (rd_sel_b) occ1++; else occ0++; end
    if (wr_vld_a) begin if (wr_sel_a) occ1++; else occ0++; end
    if (wr_vld_b) begin if (wr_sel_b) occ1++; else occ0++; end
    check("instance_single_op", 64'((occ0 > 1) || (occ1 > 1)), 64'd0);
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic vld, input logic wr, input logic sel,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [TAG_W-1:0] tag);
    req_vld_a = vld; req_wr_a = wr; req_sel_a = sel;
    req_addr_a = addr; req_wdata_a = wd; req_tag_a = tag;
  endtask

  task automatic drv_b(input logic vld, input logic wr, input logic sel,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [TAG_W-1:0] tag);
    req_vld_b = vld; req_wr_b = wr; req_sel_b = sel;
    req_addr_b = addr; req_wdata_b = wd; req_tag_b = tag;
  endtask

  task automatic idle(input int n);
    drv_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drv_b(1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_state();
    check("rst_rd_vld_a", 64'(rd_vld_a), 64'd0);
    check("rst_rd_vld_b", 64'(rd_vld_b), 64'd0);
    check("rst_wr_vld_a", 64'(wr_vld_a), 64'd0);
    check("rst_wr_vld_b", 64'(wr_vld_b), 64'd0);
    check("rst_resp_vld_a", 64'(resp_vld_a), 64'd0);
    check("rst_resp_vld_b", 64'(resp_vld_b), 64'd0);
    check("rst_sels", 64'({rd_sel_a, rd_sel_b, wr_sel_a, wr_sel_b}), 64'b1010);
    check("rst_addrs", 64'({rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b}), 64'd0);
    check("rst_wdata", 64'({wr_data_a, wr_data_b}), 64'd0);
    check("rst_rdy", 64'({req_rdy_a, req_rdy_b}), 64'b11);
  endtask

  initial begin
    rst = 1'b1;
    drv_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drv_b(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    check_reset_state();
`ifdef SRAM_PAIR_SCHED_STAT_EN
    check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
    rst = 1'b0;

    // Different instances in the same cycle issue together.
    drv_a(1'b1, 1'b0, 1'b1, 10'h10, '0, 4'd3);
    drv_b(1'b1, 1'b0, 1'b0, 10'h20, '0, 4'd5);
    step();
    idle(1);
    check("both_issue", 64'({rd_vld_a, rd_vld_b}), 64'b11);
    check("both_addr", 64'({rd_sel_a, rd_addr_a, rd_sel_b, rd_addr_b}),
          64'({1'b1, 10'h10, 1'b0, 10'h20}));
    step();
    check("both_resp_vld", 64'({resp_vld_a, resp_vld_b}), 64'b11);
    check("both_resp_tags", 64'({resp_tag_a, resp_tag_b}), 64'({4'd3, 4'd5}));
    check("resp_data_a_t1", 64'(resp_data_a), 64'(init_val(1'b1, 10'h10)));
    check("resp_data_b_t1", 64'(resp_data_b), 64'(init_val(1'b0, 10'h20)));
    idle(3);

    // Same instance: grants alternate starting from A.
    drv_a(1'b1, 1'b0, 1'b0, 10'h30, '0, 4'd1);
    drv_b(1'b1, 1'b0, 1'b0, 10'h40, '0, 4'd2);
    step();
    check("conflict_rdy", 64'({req_rdy_a, req_rdy_b}), 64'b10);
    step();
    check("rr_grant_1", 64'({rd_vld_a, rd_vld_b}), 64'b10);
    step();
    check("rr_grant_2", 64'({rd_vld_a, rd_vld_b}), 64'b01);
    drv_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drv_b(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    check("rr_grant_3", 64'({rd_vld_a, rd_vld_b}), 64'b10);
    step();
    check("rr_grant_4", 64'({rd_vld_a, rd_vld_b}), 64'b01);
`ifdef SRAM_PAIR_SCHED_STAT_EN
    check("conflict_cnt", 64'(conflict_cnt), 64'd3);
`endif
    idle(3);

    // B alone: port A idle mirrors B's sel.
    drv_b(1'b1, 1'b0, 1'b0, 10'h50, '0, 4'd7);
    step();
    idle(1);
    check("b_only_vld", 64'({rd_vld_a, rd_vld_b}), 64'b01);
    check("b_only_sels", 64'({rd_sel_a, rd_sel_b}), 64'b10);
    check("b_only_no_resp_yet", 64'(resp_vld_b), 64'd0);
    step();
    check("b_only_resp", 64'({resp_vld_b, resp_tag_b}), 64'({1'b1, 4'd7}));
    check("b_only_data", 64'(resp_data_b), 64'(init_val(1'b0, 10'h50)));
    drv_b(1'b1, 1'b0, 1'b1, 10'h51, '0, 4'd8);
    step();
    idle(1);
    check("b_only_sel1", 64'({rd_vld_b, rd_sel_a, rd_sel_b}), 64'b101);
    idle(3);

    // Write from A, read back through B.
    drv_a(1'b1, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF, 4'd0);
    step();
    drv_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drv_b(1'b1, 1'b0, 1'b1, 10'd5, '0, 4'd9);
    step();
    check("wr_cmd", 64'({wr_vld_a, wr_sel_a, wr_addr_a, wr_data_a}),
          64'({1'b1, 1'b1, 10'd5, 32'hDEADBEEF}));
    check("wr_idle_sel_b", 64'({wr_vld_b, wr_sel_b}), 64'b00);
    idle(1);
    check("rb_rd_cmd", 64'({rd_vld_b, rd_sel_b, rd_addr_b}), 64'({1'b1, 1'b1, 10'd5}));
    step();
    check("rb_resp", 64'({resp_vld_b, resp_tag_b}), 64'({1'b1, 4'd9}));
    check("rb_data", 64'(resp_data_b), 64'h0000_0000_DEAD_BEEF);
    idle(3);

    // Read and write to one instance serialize; A first after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv_a(1'b1, 1'b0, 1'b1, 10'd7, '0, 4'd4);
    drv_b(1'b1, 1'b1, 1'b1, 10'd8, 32'h1234_5678, 4'd0);
    step();
    idle(1);
    check("rw_first", 64'({rd_vld_a, wr_vld_b, rd_sel_b, wr_sel_a}), 64'b1001);
    step();
    check("rw_second", 64'({rd_vld_a, wr_vld_b, wr_sel_b, wr_sel_a}), 64'b0110);
    check("rw_resp_a", 64'({resp_vld_a, resp_tag_a}), 64'({1'b1, 4'd4}));
    idle(3);

    // Reset right after a read issue drops the response.
    drv_a(1'b1, 1'b0, 1'b0, 10'd9, '0, 4'd6);
    step();
    idle(1);
    check("pre_rst_issue", 64'(rd_vld_a), 64'd1);
    rst = 1'b1;
    step();
    check_reset_state();
    rst = 1'b0;
    step();
    check("dropped_resp", 64'({resp_vld_a, resp_vld_b}), 64'b00);
    idle(2);

    // Random traffic; address parity keeps each channel's words private.
    for (int c = 0; c < 600; c++) begin
      drv_a(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, 7) * 2), $urandom, TAG_W'($urandom));
      drv_b(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, 7) * 2 + 1), $urandom, TAG_W'($urandom));
      step();
    end
    idle(10);
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
